// File: rtl/tx_dma_chan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_dma_chan_ctrl_if
// Description : Bus bundle for the TX DMA per-channel start/stop controller.
//               Groups the command, enqueue/dequeue, status and event
//               signals. The slave modport is the controller view; the
//               master modport is the view of the logic around it.
//               Command    : cmd_vld, cmd_chan, cmd_start -> cmd_rdy
//               Enqueue    : enq_vld, enq_chan            -> enq_discard
//               Dequeue    : deq_vld, deq_chan
//               Status     : stat_chan -> stat_state, stat_cnt
//               Events     : chan_active, stop_done, err_underflow
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_dma_chan_ctrl_if #(
  parameter int CHANNELS       = 8,
  parameter int INFLIGHT_WIDTH = 8
);
  localparam int CHAN_W = $clog2(CHANNELS);

  logic                      cmd_vld;
  logic [CHAN_W-1:0]         cmd_chan;
  logic                      cmd_start;
  logic                      cmd_rdy;
  logic                      enq_vld;
  logic [CHAN_W-1:0]         enq_chan;
  logic                      enq_discard;
  logic                      deq_vld;
  logic [CHAN_W-1:0]         deq_chan;
  logic [CHAN_W-1:0]         stat_chan;
  logic [1:0]                stat_state;
  logic [INFLIGHT_WIDTH-1:0] stat_cnt;
  logic [CHANNELS-1:0]       chan_active;
  logic [CHANNELS-1:0]       stop_done;
  logic                      err_underflow;

  modport slave (
    input  cmd_vld, cmd_chan, cmd_start, enq_vld, enq_chan,
           deq_vld, deq_chan, stat_chan,
    output cmd_rdy, enq_discard, stat_state, stat_cnt,
           chan_active, stop_done, err_underflow
  );

  modport master (
    output cmd_vld, cmd_chan, cmd_start, enq_vld, enq_chan,
           deq_vld, deq_chan, stat_chan,
    input  cmd_rdy, enq_discard, stat_state, stat_cnt,
           chan_active, stop_done, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/tx_dma_chan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tx_dma_chan_ctrl
// Description : Per-channel start/stop controller for the TX DMA.
//               Gates CQ packet acceptance per channel, counts in-flight
//               packets from acceptance to EOF on the user TX MFB, and only
//               completes a stop once the channel has drained, pulsing
//               stop_done for that channel.
//               Ports: clk_i   - clock
//                      rst_n_i - asynchronous active-low reset
//                      bus     - tx_dma_chan_ctrl_if.slave (cmd/enq/deq/stat)
// Revision    : 1.0 - initial release
// ============================================================================
module tx_dma_chan_ctrl #(
  parameter int CHANNELS       = 8,
  parameter int INFLIGHT_WIDTH = 8
) (
  input  wire logic           clk_i,
  input  wire logic           rst_n_i,
  tx_dma_chan_ctrl_if.slave   bus
);
  localparam int CHAN_W = $clog2(CHANNELS);
  localparam logic [INFLIGHT_WIDTH-1:0] CNT_ONE = INFLIGHT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_STOPPING = 2'b10
  } state_e;

  state_e                    state_q [CHANNELS];
  state_e                    state_d [CHANNELS];
  logic [INFLIGHT_WIDTH-1:0] cnt_q   [CHANNELS];
  logic [INFLIGHT_WIDTH-1:0] cnt_d   [CHANNELS];
  logic [CHANNELS-1:0]       active_q, active_d;
  logic [CHANNELS-1:0]       done_q,   done_d;
  logic                      underflow_q, underflow_d;

  logic                      enq_discard_w;
  logic                      cmd_rdy_w;
  logic                      cmd_acc_w;
  logic [CHANNELS-1:0]       enq_hit_w, deq_hit_w, cmd_hit_w;

  // Acceptance is judged on registered state only, so a start issued in the
  // same cycle cannot admit the packet. A full counter also forces a drop.
  always_comb begin
    enq_discard_w = bus.enq_vld &
                    ((state_q[bus.enq_chan] != ST_RUNNING) | (&cnt_q[bus.enq_chan]));
    // A start while draining is back-pressured until the stop completes.
    cmd_rdy_w     = ~(bus.cmd_start & (state_q[bus.cmd_chan] == ST_STOPPING));
    cmd_acc_w     = bus.cmd_vld & cmd_rdy_w;
    underflow_d   = bus.deq_vld & (cnt_q[bus.deq_chan] == '0);
  end

  // Per-channel one-hot strobes for accepted enqueue, effective dequeue and
  // accepted command.
  always_comb begin
    enq_hit_w = '0;
    deq_hit_w = '0;
    cmd_hit_w = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      enq_hit_w[i] = bus.enq_vld & ~enq_discard_w & (bus.enq_chan == CHAN_W'(i));
      deq_hit_w[i] = bus.deq_vld & (bus.deq_chan == CHAN_W'(i)) & (cnt_q[i] != '0);
      cmd_hit_w[i] = cmd_acc_w & (bus.cmd_chan == CHAN_W'(i));
    end
  end

  // Counter and FSM next state. The FSM looks at the updated count so that a
  // stop coinciding with the final dequeue completes without a STOPPING hop.
  always_comb begin
    active_d = '0;
    done_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];
      if (enq_hit_w[i] & ~deq_hit_w[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (deq_hit_w[i] & ~enq_hit_w[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end

      case (state_q[i])
        ST_STOPPED: begin
          if (cmd_hit_w[i] & bus.cmd_start) begin
            state_d[i] = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (cmd_hit_w[i] & ~bus.cmd_start) begin
            if (cnt_d[i] == '0) begin
              state_d[i] = ST_STOPPED;
              done_d[i]  = 1'b1;
            end else begin
              state_d[i] = ST_STOPPING;
            end
          end
        end
        ST_STOPPING: begin
          if (cnt_d[i] == '0) begin
            state_d[i] = ST_STOPPED;
            done_d[i]  = 1'b1;
          end
        end
        default: state_d[i] = ST_STOPPED;
      endcase

      active_d[i] = (state_d[i] == ST_RUNNING);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_STOPPED;
        cnt_q[i]   <= '0;
      end
      active_q    <= '0;
      done_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      active_q    <= active_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.cmd_rdy       = cmd_rdy_w;
  assign bus.enq_discard   = enq_discard_w;
  assign bus.stat_state    = state_q[bus.stat_chan];
  assign bus.stat_cnt      = cnt_q[bus.stat_chan];
  assign bus.chan_active   = active_q;
  assign bus.stop_done     = done_q;
  assign bus.err_underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_dma_chan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_dma_chan_ctrl
// Description : Directed self-checking bench for tx_dma_chan_ctrl
//               (CHANNELS=8, INFLIGHT_WIDTH=2 so counter saturation is
//               reachable in a few cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_dma_chan_ctrl;
  localparam int CHANNELS       = 8;
  localparam int INFLIGHT_WIDTH = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  tx_dma_chan_ctrl_if #(.CHANNELS(CHANNELS), .INFLIGHT_WIDTH(INFLIGHT_WIDTH)) bus ();

  tx_dma_chan_ctrl #(.CHANNELS(CHANNELS), .INFLIGHT_WIDTH(INFLIGHT_WIDTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // later in the same cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] ch, input logic start);
    bus.cmd_vld   = 1'b1;
    bus.cmd_chan  = ch;
    bus.cmd_start = start;
    tick();
    bus.cmd_vld   = 1'b0;
  endtask

  task automatic enq(input logic [2:0] ch);
    bus.enq_vld  = 1'b1;
    bus.enq_chan = ch;
    tick();
    bus.enq_vld  = 1'b0;
  endtask

  task automatic deq(input logic [2:0] ch);
    bus.deq_vld  = 1'b1;
    bus.deq_chan = ch;
    tick();
    bus.deq_vld  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.chan_active !== 8'h00) begin n_fail++; $display("FAIL rst_active got=%h exp=00", bus.chan_active); end
    n_checks++; if (bus.stop_done !== 8'h00) begin n_fail++; $display("FAIL rst_done got=%h exp=00", bus.stop_done); end
    n_checks++; if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", bus.err_underflow); end
    bus.stat_chan = 3'd5;
    #1;
    n_checks++; if (bus.stat_state !== 2'b00 || bus.stat_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_stat got=%b/%0d exp=00/0", bus.stat_state, bus.stat_cnt); end
  endtask

  task automatic test_start_enq();
    send_cmd(3'd3, 1'b1);
    n_checks++; if (bus.chan_active !== 8'h08) begin n_fail++; $display("FAIL t1_active got=%h exp=08", bus.chan_active); end
    bus.enq_vld = 1'b1; bus.enq_chan = 3'd3;
    #1;
    n_checks++; if (bus.enq_discard !== 1'b0) begin n_fail++; $display("FAIL t1_discard got=%b exp=0", bus.enq_discard); end
    tick();
    bus.enq_vld = 1'b0;
    bus.stat_chan = 3'd3;
    #1;
    n_checks++; if (bus.stat_cnt !== 2'd1) begin n_fail++; $display("FAIL t1_cnt got=%0d exp=1", bus.stat_cnt); end
    n_checks++; if (bus.stat_state !== 2'b01) begin n_fail++; $display("FAIL t1_state got=%b exp=01", bus.stat_state); end
    deq(3'd3);
    send_cmd(3'd3, 1'b0);
    n_checks++; if (bus.stop_done !== 8'h08 || bus.chan_active !== 8'h00) begin n_fail++; $display("FAIL t1_stop got=%h/%h exp=08/00", bus.stop_done, bus.chan_active); end
    tick();
    n_checks++; if (bus.stop_done !== 8'h00) begin n_fail++; $display("FAIL t1_done_clr got=%h exp=00", bus.stop_done); end
  endtask

  task automatic test_discard();
    bus.enq_vld = 1'b1; bus.enq_chan = 3'd2;
    #1;
    n_checks++; if (bus.enq_discard !== 1'b1) begin n_fail++; $display("FAIL t2_discard_stopped got=%b exp=1", bus.enq_discard); end
    tick();
    bus.enq_vld = 1'b0;
    bus.stat_chan = 3'd2;
    #1;
    n_checks++; if (bus.stat_cnt !== 2'd0) begin n_fail++; $display("FAIL t2_cnt got=%0d exp=0", bus.stat_cnt); end
    bus.cmd_vld = 1'b1; bus.cmd_chan = 3'd2; bus.cmd_start = 1'b1;
    bus.enq_vld = 1'b1; bus.enq_chan = 3'd2;
    #1;
    n_checks++; if (bus.enq_discard !== 1'b1) begin n_fail++; $display("FAIL t2_discard_samecyc got=%b exp=1", bus.enq_discard); end
    tick();
    bus.cmd_vld = 1'b0; bus.enq_vld = 1'b0;
    n_checks++; if (bus.chan_active !== 8'h04 || bus.stat_cnt !== 2'd0) begin n_fail++; $display("FAIL t2_after got=%h/%0d exp=04/0", bus.chan_active, bus.stat_cnt); end
    send_cmd(3'd2, 1'b0);
    tick();
  endtask

  task automatic test_drain();
    send_cmd(3'd1, 1'b1);
    enq(3'd1); enq(3'd1); enq(3'd1);
    bus.stat_chan = 3'd1;
    #1;
    n_checks++; if (bus.stat_cnt !== 2'd3) begin n_fail++; $display("FAIL t3_cnt3 got=%0d exp=3", bus.stat_cnt); end
    send_cmd(3'd1, 1'b0);
    n_checks++; if (bus.stat_state !== 2'b10 || bus.chan_active !== 8'h00 || bus.stop_done !== 8'h00) begin n_fail++; $display("FAIL t3_stopping got=%b/%h/%h exp=10/00/00", bus.stat_state, bus.chan_active, bus.stop_done); end
    bus.cmd_vld = 1'b1; bus.cmd_chan = 3'd1; bus.cmd_start = 1'b1;
    #1;
    n_checks++; if (bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL t3_rdy_hold got=%b exp=0", bus.cmd_rdy); end
    tick();
    bus.cmd_vld = 1'b0;
    n_checks++; if (bus.stat_state !== 2'b10) begin n_fail++; $display("FAIL t3_still_stopping got=%b exp=10", bus.stat_state); end
    bus.cmd_start = 1'b0;
    #1;
    n_checks++; if (bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL t3_rdy_stop got=%b exp=1", bus.cmd_rdy); end
    deq(3'd1);
    deq(3'd1);
    n_checks++; if (bus.stop_done !== 8'h00 || bus.stat_cnt !== 2'd1) begin n_fail++; $display("FAIL t3_mid got=%h/%0d exp=00/1", bus.stop_done, bus.stat_cnt); end
    deq(3'd1);
    n_checks++; if (bus.stop_done !== 8'h02 || bus.stat_state !== 2'b00) begin n_fail++; $display("FAIL t3_done got=%h/%b exp=02/00", bus.stop_done, bus.stat_state); end
    tick();
    n_checks++; if (bus.stop_done !== 8'h00) begin n_fail++; $display("FAIL t3_done_clr got=%h exp=00", bus.stop_done); end
  endtask

  task automatic test_stop_idle_underflow();
    send_cmd(3'd0, 1'b1);
    send_cmd(3'd0, 1'b0);
    bus.stat_chan = 3'd0;
    #1;
    n_checks++; if (bus.stop_done !== 8'h01 || bus.stat_state !== 2'b00) begin n_fail++; $display("FAIL t4_done got=%h/%b exp=01/00", bus.stop_done, bus.stat_state); end
    send_cmd(3'd0, 1'b0);
    n_checks++; if (bus.stop_done !== 8'h00) begin n_fail++; $display("FAIL t4_stop_stopped got=%h exp=00", bus.stop_done); end
    deq(3'd0);
    n_checks++; if (bus.err_underflow !== 1'b1 || bus.stat_cnt !== 2'd0) begin n_fail++; $display("FAIL t4_underflow got=%b/%0d exp=1/0", bus.err_underflow, bus.stat_cnt); end
    tick();
    n_checks++; if (bus.err_underflow !== 1'b0) begin n_fail++; $display("FAIL t4_underflow_clr got=%b exp=0", bus.err_underflow); end
  endtask

  task automatic test_saturate();
    send_cmd(3'd4, 1'b1);
    enq(3'd4); enq(3'd4); enq(3'd4);
    bus.stat_chan = 3'd4;
    bus.enq_vld = 1'b1; bus.enq_chan = 3'd4;
    #1;
    n_checks++; if (bus.enq_discard !== 1'b1) begin n_fail++; $display("FAIL t5_full_discard got=%b exp=1", bus.enq_discard); end
    tick();
    bus.enq_vld = 1'b0;
    n_checks++; if (bus.stat_cnt !== 2'd3) begin n_fail++; $display("FAIL t5_full_cnt got=%0d exp=3", bus.stat_cnt); end
    deq(3'd4);
    bus.enq_vld = 1'b1; bus.enq_chan = 3'd4;
    bus.deq_vld = 1'b1; bus.deq_chan = 3'd4;
    #1;
    n_checks++; if (bus.enq_discard !== 1'b0) begin n_fail++; $display("FAIL t5_both_discard got=%b exp=0", bus.enq_discard); end
    tick();
    bus.enq_vld = 1'b0; bus.deq_vld = 1'b0;
    n_checks++; if (bus.stat_cnt !== 2'd2) begin n_fail++; $display("FAIL t5_both_cnt got=%0d exp=2", bus.stat_cnt); end
    deq(3'd4); deq(3'd4);
    send_cmd(3'd4, 1'b0);
    n_checks++; if (bus.stop_done !== 8'h10) begin n_fail++; $display("FAIL t5_done got=%h exp=10", bus.stop_done); end
    tick();
  endtask

  task automatic test_back_to_back();
    send_cmd(3'd5, 1'b1);
    send_cmd(3'd6, 1'b1);
    enq(3'd5);
    send_cmd(3'd5, 1'b0);
    bus.stat_chan = 3'd5;
    #1;
    n_checks++; if (bus.stat_state !== 2'b10 || bus.chan_active !== 8'h40) begin n_fail++; $display("FAIL t6_setup got=%b/%h exp=10/40", bus.stat_state, bus.chan_active); end
    // ch5 drains via its last DEQ while ch6 is stopped empty in the same cycle.
    bus.cmd_vld = 1'b1; bus.cmd_chan = 3'd6; bus.cmd_start = 1'b0;
    bus.deq_vld = 1'b1; bus.deq_chan = 3'd5;
    tick();
    bus.cmd_vld = 1'b0; bus.deq_vld = 1'b0;
    n_checks++; if (bus.stop_done !== 8'h60 || bus.chan_active !== 8'h00) begin n_fail++; $display("FAIL t6_done got=%h/%h exp=60/00", bus.stop_done, bus.chan_active); end
    tick();
    n_checks++; if (bus.stop_done !== 8'h00) begin n_fail++; $display("FAIL t6_done_clr got=%h exp=00", bus.stop_done); end
  endtask

  task automatic test_async_reset();
    send_cmd(3'd0, 1'b1);
    send_cmd(3'd7, 1'b1);
    enq(3'd7); enq(3'd7);
    send_cmd(3'd7, 1'b0);
    deq(3'd3);
    bus.stat_chan = 3'd7;
    #1;
    n_checks++; if (bus.err_underflow !== 1'b1 || bus.chan_active !== 8'h01 || bus.stat_cnt !== 2'd2 || bus.stat_state !== 2'b10) begin
      n_fail++; $display("FAIL t6_pre_reset got=%b/%h/%0d/%b exp=1/01/2/10", bus.err_underflow, bus.chan_active, bus.stat_cnt, bus.stat_state);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.chan_active !== 8'h00 || bus.err_underflow !== 1'b0 || bus.stop_done !== 8'h00) begin
      n_fail++; $display("FAIL t6_reset_out got=%h/%b/%h exp=00/0/00", bus.chan_active, bus.err_underflow, bus.stop_done);
    end
    n_checks++; if (bus.stat_cnt !== 2'd0 || bus.stat_state !== 2'b00) begin n_fail++; $display("FAIL t6_reset_stat got=%0d/%b exp=0/00", bus.stat_cnt, bus.stat_state); end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.stop_done !== 8'h00 || bus.stat_state !== 2'b00) begin n_fail++; $display("FAIL t6_post_reset got=%h/%b exp=00/00", bus.stop_done, bus.stat_state); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.cmd_vld   = 1'b0;
    bus.cmd_chan  = '0;
    bus.cmd_start = 1'b0;
    bus.enq_vld   = 1'b0;
    bus.enq_chan  = '0;
    bus.deq_vld   = 1'b0;
    bus.deq_chan  = '0;
    bus.stat_chan = '0;
    repeat (3) @(posedge clk);
    test_reset();
    #1;
    rst_n = 1'b1;
    tick();
    test_start_enq();
    test_discard();
    test_drain();
    test_stop_idle_underflow();
    test_saturate();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
